// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions: active-low glyphs (bit0=a .. bit6=g), the blank
// pattern and the receiver FSM state type. The display encoder uses the same glyph table.
package sevenseg_pkg;

   // Index i holds the glyph for hex value i (0..F).
   localparam logic [15:0][6:0] GLYPHS = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TRACK = 2'd1,
      ST_HOLD  = 2'd2
   } rx_state_t;

endpackage

// File: rtl/sevenseg_decode.sv
// Combinational glyph decoder: active-low segment pattern to hex value plus legal flag.
module sevenseg_decode
   import sevenseg_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] value,
   output logic       legal
);

   always_comb begin
      value = '0;
      legal = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (pattern == GLYPHS[i]) begin
            value = 4'(i);
            legal = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sevenseg_rx.sv
// Seven-segment display receiver: recovers hex digits from a multiplexed, active-low
// segment/anode bus. Define SEVENSEG_RX_BLANK_EN to accept the all-off pattern as a blank digit.
//
// state    | meaning
// ST_IDLE  | no single digit selected; waiting for a selected sample
// ST_TRACK | counting consecutive identical samples toward STABLE_CYCLES
// ST_HOLD  | current sample already captured; waiting for anode/pattern change
module sevenseg_rx
   import sevenseg_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [6:0]              segments,
   input  logic [NUM_DIGITS-1:0]   an_n,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic                    illegal,
   output logic [NUM_DIGITS-1:0]   err_sticky,
   output logic                    frame_done
);

   localparam int         IDXW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [8:0] STABLE9 = 9'(STABLE_CYCLES);

   logic [6:0]              seg_in_q;
   logic [NUM_DIGITS-1:0]   an_in_q;
   rx_state_t               state_q, state_d;
   logic [7:0]              cnt_q, cnt_d;
   logic [6:0]              trk_seg_q, trk_seg_d;
   logic [IDXW-1:0]         trk_idx_q, trk_idx_d;
   logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
   logic [NUM_DIGITS-1:0]   valid_q, valid_d;
   logic [NUM_DIGITS-1:0]   err_q, err_d;
   logic [NUM_DIGITS-1:0]   seen_q, seen_d;
   logic                    illegal_q, illegal_d;
   logic                    frame_done_q, frame_done_d;

   logic [NUM_DIGITS-1:0]   sel_vec;
   logic                    selected;
   logic [IDXW-1:0]         sel_idx;
   logic                    same;
   logic                    capture;
   logic [8:0]              cnt_inc;
   logic [3:0]              dec_value;
   logic                    dec_legal;

   sevenseg_decode u_decode (
      .pattern (seg_in_q),
      .value   (dec_value),
      .legal   (dec_legal)
   );

   assign sel_vec  = ~an_in_q;
   assign selected = $onehot(sel_vec);
   assign cnt_inc  = {1'b0, cnt_q} + 9'd1;

   always_comb begin
      sel_idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (sel_vec[i]) sel_idx = IDXW'(i);
      end
   end

   assign same = (sel_idx == trk_idx_q) && (seg_in_q == trk_seg_q);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      trk_seg_d = trk_seg_q;
      trk_idx_d = trk_idx_q;
      capture   = 1'b0;
      if (!selected) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_TRACK: begin
               if (same) begin
                  if (cnt_inc >= STABLE9) begin
                     cnt_d   = 8'(STABLE_CYCLES);
                     state_d = ST_HOLD;
                     capture = 1'b1;
                  end else begin
                     cnt_d = cnt_inc[7:0];
                  end
               end else begin
                  cnt_d     = 8'd1;
                  trk_seg_d = seg_in_q;
                  trk_idx_d = sel_idx;
               end
            end
            ST_HOLD: begin
               if (!same) begin
                  state_d   = ST_TRACK;
                  cnt_d     = 8'd1;
                  trk_seg_d = seg_in_q;
                  trk_idx_d = sel_idx;
               end
            end
            default: begin
               state_d   = ST_TRACK;
               cnt_d     = 8'd1;
               trk_seg_d = seg_in_q;
               trk_idx_d = sel_idx;
            end
         endcase
      end
   end

   // Seen mask clears when full; a capture on the clearing edge re-marks its digit.
   always_comb begin
      digits_d     = digits_q;
      valid_d      = valid_q;
      err_d        = err_q;
      illegal_d    = 1'b0;
      frame_done_d = &seen_q;
      seen_d       = (&seen_q) ? '0 : seen_q;
      if (capture) begin
         seen_d[trk_idx_q] = 1'b1;
         if (dec_legal) begin
            digits_d[4*trk_idx_q +: 4] = dec_value;
            valid_d[trk_idx_q]         = 1'b1;
         end
`ifdef SEVENSEG_RX_BLANK_EN
         else if (seg_in_q == SEG_BLANK) begin
            valid_d[trk_idx_q] = 1'b0;
         end
`endif
         else begin
            err_d[trk_idx_q] = 1'b1;
            illegal_d        = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_in_q     <= '1;
         an_in_q      <= '1;
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         trk_seg_q    <= '1;
         trk_idx_q    <= '0;
         digits_q     <= '0;
         valid_q      <= '0;
         err_q        <= '0;
         seen_q       <= '0;
         illegal_q    <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         seg_in_q     <= segments;
         an_in_q      <= an_n;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         trk_seg_q    <= trk_seg_d;
         trk_idx_q    <= trk_idx_d;
         digits_q     <= digits_d;
         valid_q      <= valid_d;
         err_q        <= err_d;
         seen_q       <= seen_d;
         illegal_q    <= illegal_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign digits      = digits_q;
   assign digit_valid = valid_q;
   assign err_sticky  = err_q;
   assign illegal     = illegal_q;
   assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_sevenseg_rx.sv
// Scoreboard bench for sevenseg_rx: directed segment/anode sequences push expected
// output events; a negedge monitor pops and compares whenever the outputs change or pulse.
module tb_sevenseg_rx;

   logic        clk;
   logic        rst_n;
   logic [6:0]  segments;
   logic [3:0]  an_n;
   logic [15:0] digits;
   logic [3:0]  digit_valid;
   logic        illegal;
   logic [3:0]  err_sticky;
   logic        frame_done;

   sevenseg_rx #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .segments    (segments),
      .an_n        (an_n),
      .digits      (digits),
      .digit_valid (digit_valid),
      .illegal     (illegal),
      .err_sticky  (err_sticky),
      .frame_done  (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]  tag;
      logic [15:0] dg;
      logic [3:0]  v;
      logic [3:0]  e;
      logic        ill;
      logic        fr;
   } ev_t;

   ev_t  exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [23:0] prev_tuple = '0;

   task automatic expect_ev(input logic [7:0] tag, input logic [15:0] dg, input logic [3:0] v,
                            input logic [3:0] e, input logic ill, input logic fr);
      ev_t x;
      x.tag = tag; x.dg = dg; x.v = v; x.e = e; x.ill = ill; x.fr = fr;
      exp_q.push_back(x);
   endtask

   task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
      an_n     = an;
      segments = seg;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string name);
      n_cmp++;
      if (digits !== 16'h0 || digit_valid !== 4'h0 || err_sticky !== 4'h0 ||
          illegal !== 1'b0 || frame_done !== 1'b0) begin
         n_bad++;
         $display("FAIL %s: got dg=%h v=%b e=%b ill=%b fr=%b, want all zero",
                  name, digits, digit_valid, err_sticky, illegal, frame_done);
      end
   endtask

   always @(negedge clk) begin
      logic [23:0] cur;
      ev_t x;
      cur = {digits, digit_valid, err_sticky};
      if (rst_n === 1'b1 && (illegal === 1'b1 || frame_done === 1'b1 || cur !== prev_tuple)) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got dg=%h v=%b e=%b ill=%b fr=%b, want no event",
                     digits, digit_valid, err_sticky, illegal, frame_done);
         end else begin
            x = exp_q.pop_front();
            if (digits !== x.dg || digit_valid !== x.v || err_sticky !== x.e ||
                illegal !== x.ill || frame_done !== x.fr) begin
               n_bad++;
               $display("FAIL event_%0d: got dg=%h v=%b e=%b ill=%b fr=%b, want dg=%h v=%b e=%b ill=%b fr=%b",
                        x.tag, digits, digit_valid, err_sticky, illegal, frame_done,
                        x.dg, x.v, x.e, x.ill, x.fr);
            end
         end
      end
      prev_tuple = cur;
   end

   initial begin
      rst_n    = 1'b0;
      segments = 7'h7F;
      an_n     = 4'hF;
      repeat (3) @(negedge clk);
      check_reset_state("reset_initial");
      @(posedge clk); #1;
      rst_n = 1'b1;
      hold(4'hF, 7'h7F, 3);

      // Digit 0 = '2', held well past the stable count: one capture only.
      expect_ev(8'd1, 16'h0002, 4'b0001, 4'b0000, 1'b0, 1'b0);
      hold(4'b1110, 7'h24, 8);
      hold(4'hF, 7'h7F, 3);

      // Three samples of '1' then '8': only '8' is captured.
      expect_ev(8'd2, 16'h0008, 4'b0001, 4'b0000, 1'b0, 1'b0);
      hold(4'b1110, 7'h79, 3);
      hold(4'b1110, 7'h00, 4);
      hold(4'hF, 7'h7F, 3);

      // Only segment a lit on digit 1: illegal.
      expect_ev(8'd3, 16'h0008, 4'b0001, 4'b0010, 1'b1, 1'b0);
      hold(4'b1101, 7'h7E, 4);
      hold(4'hF, 7'h7F, 3);

      // Scan 1, A, C, F across digits 0..3; completes the frame.
      expect_ev(8'd4, 16'h0001, 4'b0001, 4'b0010, 1'b0, 1'b0);
      expect_ev(8'd5, 16'h00A1, 4'b0011, 4'b0010, 1'b0, 1'b0);
      expect_ev(8'd6, 16'h0CA1, 4'b0111, 4'b0010, 1'b0, 1'b0);
      expect_ev(8'd7, 16'hFCA1, 4'b1111, 4'b0010, 1'b0, 1'b0);
      expect_ev(8'd8, 16'hFCA1, 4'b1111, 4'b0010, 1'b0, 1'b1);
      hold(4'b1110, 7'h79, 5);
      hold(4'b1101, 7'h08, 5);
      hold(4'b1011, 7'h46, 5);
      hold(4'b0111, 7'h0E, 5);
      hold(4'hF, 7'h7F, 4);

      // Two anodes low: ignored.
      hold(4'b1100, 7'h24, 10);

      // Reset in the middle of tracking, then a short run that must not capture.
      hold(4'b1110, 7'h30, 2);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_state("reset_mid_track");
      @(posedge clk); #1;
      rst_n = 1'b1;
      hold(4'b1110, 7'h30, 3);
      hold(4'hF, 7'h7F, 4);
      expect_ev(8'd9, 16'h0003, 4'b0001, 4'b0000, 1'b0, 1'b0);
      hold(4'b1110, 7'h30, 4);
      hold(4'hF, 7'h7F, 3);

      // Digit 1 = '5', then blank, then 'b' and 'E' to finish a frame.
      expect_ev(8'd10, 16'h0053, 4'b0011, 4'b0000, 1'b0, 1'b0);
`ifdef SEVENSEG_RX_BLANK_EN
      expect_ev(8'd11, 16'h0053, 4'b0001, 4'b0000, 1'b0, 1'b0);
      expect_ev(8'd12, 16'h0B53, 4'b0101, 4'b0000, 1'b0, 1'b0);
      expect_ev(8'd13, 16'hEB53, 4'b1101, 4'b0000, 1'b0, 1'b0);
      expect_ev(8'd14, 16'hEB53, 4'b1101, 4'b0000, 1'b0, 1'b1);
`else
      expect_ev(8'd11, 16'h0053, 4'b0011, 4'b0010, 1'b1, 1'b0);
      expect_ev(8'd12, 16'h0B53, 4'b0111, 4'b0010, 1'b0, 1'b0);
      expect_ev(8'd13, 16'hEB53, 4'b1111, 4'b0010, 1'b0, 1'b0);
      expect_ev(8'd14, 16'hEB53, 4'b1111, 4'b0010, 1'b0, 1'b1);
`endif
      hold(4'b1101, 7'h12, 4);
      hold(4'b1101, 7'h7F, 4);
      hold(4'b1011, 7'h03, 4);
      hold(4'b0111, 7'h06, 4);
      hold(4'hF, 7'h7F, 10);

      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL missing_events: got %0d pending, want 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
